cordic_iter_ctrl: RTL and testbench

Iteration controller for the rotation-mode CORDIC datapath, directly upstream of the ALU stage. It accepts a vector and a target angle, performs quadrant pre-rotation, and holds the x/y/angle working registers. Each cycle it drives the ALU stage with the current operands, the arithmetic shifts by the iteration index, the direction bit d_i and the arctangent constant, then captures the ALU results. After N_ITER iterations it presents the rotated vector and the residual angle.

---
 rtl/cordic_iter_ctrl.sv | 147 ++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// Rotation-mode CORDIC iteration controller: quadrant pre-rotation, x/y/z working
// registers, per-iteration operand generation for the ALU stage and result capture.
module cordic_iter_ctrl #(
    parameter int DW     = 16,
    parameter int N_ITER = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] z_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] x_res,
    output logic [DW-1:0] y_res,
    output logic [DW-1:0] z_res,
    output logic [DW-1:0] alu_x_init,
    output logic [DW-1:0] alu_y_init,
    output logic [DW-1:0] alu_x_shift,
    output logic [DW-1:0] alu_y_shift,
    output logic          alu_d_i,
    output logic [DW-1:0] alu_angle,
    output logic [DW-1:0] alu_delta_angle,
    input  logic [DW-1:0] alu_x_out,
    input  logic [DW-1:0] alu_y_out,
    input  logic [DW-1:0] alu_angle_out
);

    // start is a request pulse honoured only in IDLE (never queued); done is a
    // one-cycle pulse and x_res/y_res/z_res hold their value until the next done.
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    localparam logic [DW-1:0] QTR_POS  = 16'h4000;
    localparam logic [DW-1:0] QTR_NEG  = 16'hC000;
    localparam logic [DW-1:0] MIN_VAL  = 16'h8000;
    localparam logic [DW-1:0] MAX_VAL  = 16'h7FFF;
    localparam logic [3:0]    LAST_IDX = 4'(N_ITER - 1);

    state_t        state_q;
    logic [3:0]    i_q;
    logic [DW-1:0] x_q, y_q, z_q;
    logic [DW-1:0] x_res_q, y_res_q, z_res_q;
    logic          busy_q, done_q;
    logic          in_iter;

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        return (v == MIN_VAL) ? MAX_VAL : ({DW{1'b0}} - v);
    endfunction

    function automatic logic [DW-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h2000;
            4'd1:    return 16'h12E4;
            4'd2:    return 16'h09FB;
            4'd3:    return 16'h0511;
            4'd4:    return 16'h028B;
            4'd5:    return 16'h0146;
            4'd6:    return 16'h00A3;
            4'd7:    return 16'h0051;
            4'd8:    return 16'h0029;
            4'd9:    return 16'h0014;
            4'd10:   return 16'h000A;
            4'd11:   return 16'h0005;
            4'd12:   return 16'h0003;
            4'd13:   return 16'h0001;
            4'd14:   return 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= 4'd0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_res_q <= '0;
            y_res_q <= '0;
            z_res_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                        busy_q  <= 1'b1;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    // Fold |angle| > 90 deg into the convergence range with an exact quarter turn.
                    if ($signed(z_q) > $signed(QTR_POS)) begin
                        x_q <= neg_sat(y_q);
                        y_q <= x_q;
                        z_q <= z_q - QTR_POS;
                    end else if ($signed(z_q) < $signed(QTR_NEG)) begin
                        x_q <= y_q;
                        y_q <= neg_sat(x_q);
                        z_q <= z_q + QTR_POS;
                    end
                    i_q     <= 4'd0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    x_q <= alu_x_out;
                    y_q <= alu_y_out;
                    z_q <= alu_angle_out;
                    i_q <= i_q + 4'd1;
                    if (i_q == LAST_IDX) begin
                        x_res_q <= alu_x_out;
                        y_res_q <= alu_y_out;
                        z_res_q <= alu_angle_out;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Direction and arctangent are only meaningful while iterating; outside ITER they
    // read as zero so the whole ALU operand bus is quiet after reset.
    assign in_iter         = (state_q == S_ITER);
    assign alu_x_init      = x_q;
    assign alu_y_init      = y_q;
    assign alu_angle       = z_q;
    assign alu_x_shift     = $signed(x_q) >>> i_q;
    assign alu_y_shift     = $signed(y_q) >>> i_q;
    assign alu_d_i         = in_iter & ~z_q[DW-1];
    assign alu_delta_angle = in_iter ? atan_lut(i_q) : '0;

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_res = x_res_q;
    assign y_res = y_res_q;
    assign z_res = z_res_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: behavioural ALU stage, reference CORDIC
// model feeding an expected-result queue, and one task per scenario.
module tb_cordic_iter_ctrl;
    localparam int N_ITER = 16;
    localparam int W      = 48;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] x_in, y_in, z_in;
    logic        busy, done, alu_d_i;
    logic [15:0] x_res, y_res, z_res;
    logic [15:0] alu_x_init, alu_y_init, alu_x_shift, alu_y_shift, alu_angle, alu_delta_angle;
    logic [15:0] alu_x_out, alu_y_out, alu_angle_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    logic [15:0] lut [16] = '{16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146,
                              16'h00A3, 16'h0051, 16'h0029, 16'h0014, 16'h000A, 16'h0005,
                              16'h0003, 16'h0001, 16'h0001, 16'h0000};

    cordic_iter_ctrl #(.DW(16), .N_ITER(N_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done), .x_res(x_res), .y_res(y_res), .z_res(z_res),
        .alu_x_init(alu_x_init), .alu_y_init(alu_y_init),
        .alu_x_shift(alu_x_shift), .alu_y_shift(alu_y_shift),
        .alu_d_i(alu_d_i), .alu_angle(alu_angle), .alu_delta_angle(alu_delta_angle),
        .alu_x_out(alu_x_out), .alu_y_out(alu_y_out), .alu_angle_out(alu_angle_out)
    );

    always #5 clk = ~clk;

    // ALU stage: d=1 rotates counter-clockwise and consumes angle.
    assign alu_x_out     = alu_d_i ? alu_x_init - alu_y_shift : alu_x_init + alu_y_shift;
    assign alu_y_out     = alu_d_i ? alu_y_init + alu_x_shift : alu_y_init - alu_x_shift;
    assign alu_angle_out = alu_d_i ? alu_angle - alu_delta_angle : alu_angle + alu_delta_angle;

    function automatic logic [15:0] neg_sat(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7FFF : (16'h0000 - v);
    endfunction

    function automatic logic [W-1:0] pre_rot(input logic [W-1:0] s);
        logic [15:0] x, y, z;
        {x, y, z} = s;
        if ($signed(z) > 16'sh4000) return {neg_sat(y), x, z - 16'h4000};
        if ($signed(z) < 16'shC000) return {y, neg_sat(x), z + 16'h4000};
        return s;
    endfunction

    function automatic logic [W-1:0] iter_step(input logic [W-1:0] s, input int k);
        logic [15:0] x, y, z, xs, ys;
        {x, y, z} = s;
        xs = $signed(x) >>> k;
        ys = $signed(y) >>> k;
        if (!z[15]) return {x - ys, y + xs, z - lut[k]};
        return {x + ys, y - xs, z + lut[k]};
    endfunction

    function automatic logic [W-1:0] model(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z);
        logic [W-1:0] s;
        s = pre_rot({x, y, z});
        for (int k = 0; k < N_ITER; k++) s = iter_step(s, k);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        exp_q.push_back(model(x, y, z));
    endtask

    // Returns the number of cycles after the start cycle at which done appeared.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit ok);
        cycles   = 0;
        busy_cnt = 0;
        ok       = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                cycles = n;
                ok     = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got busy/done %b expected 00", {busy, done});
        end
        n_cmp++;
        if ({x_res, y_res, z_res} !== '0) begin
            n_err++; $display("FAIL reset_results: got %h expected 0", {x_res, y_res, z_res});
        end
        n_cmp++;
        if ({alu_x_init, alu_y_init, alu_x_shift, alu_y_shift, alu_d_i, alu_angle, alu_delta_angle} !== '0) begin
            n_err++;
            $display("FAIL reset_alu_bus: got %h expected 0",
                     {alu_x_init, alu_y_init, alu_x_shift, alu_y_shift, alu_d_i, alu_angle, alu_delta_angle});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL idle_after_reset: got busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_nominal();
        int cz [4] = '{0, 'h2000, 'h4000, 'h6000};
        int ex [4] = '{16468, 11645, 0, -11645};
        int ey [4] = '{0, 11645, 16468, 11645};
        int cyc, bcnt, d;
        bit ok;
        logic [W-1:0] exp_v;
        for (int c = 0; c < 4; c++) begin
            drive_start(16'd10000, 16'd0, 16'(cz[c]));
            wait_done(cyc, bcnt, ok);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL nominal_timeout case %0d: no done within 40 cycles", c);
                continue;
            end
            n_cmp++;
            if ({x_res, y_res, z_res} !== exp_v) begin
                n_err++; $display("FAIL nominal_exact case %0d: got %h expected %h", c, {x_res, y_res, z_res}, exp_v);
            end
            n_cmp++;
            if (cyc != 18) begin
                n_err++; $display("FAIL nominal_latency case %0d: got %0d expected 18", c, cyc);
            end
            n_cmp++;
            if (bcnt != 17) begin
                n_err++; $display("FAIL nominal_busy_len case %0d: got %0d expected 17", c, bcnt);
            end
            d = int'($signed(x_res)) - ex[c];
            n_cmp++;
            if (d > 4 || d < -4) begin
                n_err++; $display("FAIL nominal_x case %0d: got %0d expected %0d+-4", c, $signed(x_res), ex[c]);
            end
            d = int'($signed(y_res)) - ey[c];
            n_cmp++;
            if (d > 4 || d < -4) begin
                n_err++; $display("FAIL nominal_y case %0d: got %0d expected %0d+-4", c, $signed(y_res), ey[c]);
            end
            if (c == 0) begin
                d = int'($signed(z_res));
                n_cmp++;
                if (d > 2 || d < -2) begin
                    n_err++; $display("FAIL nominal_z case 0: got %0d expected 0+-2", d);
                end
            end
            tick();
        end
    endtask

    task automatic test_alu_trace();
        logic [W-1:0] s, exp_v;
        logic [15:0] mx, my, mz, xs, ys;
        logic [96:0] got_bus, exp_bus;
        drive_start(16'd10000, 16'd0, 16'h6000);
        s = pre_rot({16'd10000, 16'd0, 16'h6000});
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL trace_pre_busy: got %b expected 1", busy);
        end
        for (int k = 0; k < N_ITER; k++) begin
            tick();
            {mx, my, mz} = s;
            xs = $signed(mx) >>> k;
            ys = $signed(my) >>> k;
            exp_bus = {mx, my, xs, ys, ~mz[15], mz, lut[k]};
            got_bus = {alu_x_init, alu_y_init, alu_x_shift, alu_y_shift, alu_d_i, alu_angle, alu_delta_angle};
            n_cmp++;
            if (got_bus !== exp_bus) begin
                n_err++; $display("FAIL trace_iter%0d: got %h expected %h", k, got_bus, exp_bus);
            end
            s = iter_step(s, k);
        end
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({done, x_res, y_res, z_res} !== {1'b1, exp_v}) begin
            n_err++; $display("FAIL trace_result: got %h expected %h", {done, x_res, y_res, z_res}, {1'b1, exp_v});
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        int done_at = 0;
        logic [W-1:0] got_v, exp_v;
        got_v = '0;
        drive_start(16'd10000, 16'd0, 16'h2000);
        for (int n = 1; n <= 40; n++) begin
            tick();
            start = (n == 3 || n == 10);
            x_in  = start ? 16'h1234 : 16'd10000;
            z_in  = start ? 16'h7000 : 16'h2000;
            if (done === 1'b1) begin
                n_done++;
                done_at = n;
                got_v   = {x_res, y_res, z_res};
            end
        end
        start = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (n_done != 1) begin
            n_err++; $display("FAIL ignored_start_done_count: got %0d expected 1", n_done);
        end
        n_cmp++;
        if (done_at != 18) begin
            n_err++; $display("FAIL ignored_start_latency: got %0d expected 18", done_at);
        end
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++; $display("FAIL ignored_start_result: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int cyc, bcnt;
        bit ok;
        logic [W-1:0] exp_v;
        x_in = 16'd10000; y_in = 16'd0; z_in = 16'h1000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++; $display("FAIL reset_mid_flags: got busy/done %b expected 00", {busy, done});
        end
        n_cmp++;
        if ({x_res, y_res, z_res} !== '0) begin
            n_err++; $display("FAIL reset_mid_results: got %h expected 0", {x_res, y_res, z_res});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin
            n_err++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", n_done);
        end
        drive_start(16'd10000, 16'd0, 16'h2000);
        wait_done(cyc, bcnt, ok);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (!ok || {x_res, y_res, z_res} !== exp_v) begin
            n_err++; $display("FAIL reset_mid_fresh_run: got %h expected %h", {x_res, y_res, z_res}, exp_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt, d, active;
        bit ok;
        logic [W-1:0] exp_v;
        drive_start(16'd10000, 16'd0, 16'h0000);
        wait_done(cyc, bcnt, ok);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (!ok || {x_res, y_res, z_res} !== exp_v) begin
            n_err++; $display("FAIL b2b_first: got %h expected %h", {x_res, y_res, z_res}, exp_v);
        end
        tick();
        drive_start(16'hD8F0, 16'd0, 16'hA000);
        wait_done(cyc, bcnt, ok);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (!ok || cyc != 18) begin
            n_err++; $display("FAIL b2b_latency: got %0d expected 18", cyc);
        end
        n_cmp++;
        if ({x_res, y_res, z_res} !== exp_v) begin
            n_err++; $display("FAIL b2b_second: got %h expected %h", {x_res, y_res, z_res}, exp_v);
        end
        d = int'($signed(x_res)) - 11645;
        n_cmp++;
        if (d > 4 || d < -4) begin
            n_err++; $display("FAIL b2b_x: got %0d expected 11645+-4", $signed(x_res));
        end
        d = int'($signed(y_res)) - 11645;
        n_cmp++;
        if (d > 4 || d < -4) begin
            n_err++; $display("FAIL b2b_y: got %0d expected 11645+-4", $signed(y_res));
        end
        // Now in DONE: a start here must be dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        active = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (busy === 1'b1 || done === 1'b1) active++;
        end
        n_cmp++;
        if (active != 0) begin
            n_err++; $display("FAIL start_in_done_ignored: got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] bx [5] = '{16'h0000, 16'h8000, 16'd10000, 16'd5000, 16'd12000};
        logic [15:0] by [5] = '{16'h8000, 16'h0000, 16'd0, 16'hE4A8, 16'd3000};
        logic [15:0] bz [5] = '{16'h6000, 16'h8000, 16'hC000, 16'h4001, 16'hBFFF};
        logic [15:0] x, y, z;
        int cyc, bcnt;
        bit ok;
        logic [W-1:0] exp_v;
        for (int c = 0; c < 9; c++) begin
            if (c < 5) begin
                x = bx[c]; y = by[c]; z = bz[c];
            end else begin
                x = 16'($urandom_range(0, 39600) - 19800);
                y = 16'($urandom_range(0, 39600) - 19800);
                z = 16'($urandom_range(0, 65535));
            end
            drive_start(x, y, z);
            wait_done(cyc, bcnt, ok);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (!ok || {x_res, y_res, z_res} !== exp_v) begin
                n_err++;
                $display("FAIL boundary case %0d (x=%h y=%h z=%h): got %h expected %h",
                         c, x, y, z, {x_res, y_res, z_res}, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_alu_trace();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_boundaries();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
